// File: rtl/sar_ctrl_param_if.sv
// Bus bundle for the SAR conversion controller.
// slave modport  : used by the controller (control/weight inputs, matrix/status outputs).
// master modport : used by whatever drives the controller.
// Inputs to the controller : start, abort, continuous, avg_control[2:0], sample_cycles[2:0],
//                            comparator_in, weight_we, weight_addr, weight_data.
// Outputs of the controller: sample, nsample, enable, busy, p_switch, n_switch, result,
//                            result_valid.
interface sar_ctrl_param_if #(
    parameter int MATRIX_BITS = 12,
    parameter int STEPS       = 15
);
    localparam int AW = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic                   start;
    logic                   abort;
    logic                   continuous;
    logic [2:0]             avg_control;
    logic [2:0]             sample_cycles;
    logic                   comparator_in;
    logic                   weight_we;
    logic [AW-1:0]          weight_addr;
    logic [MATRIX_BITS-1:0] weight_data;

    logic                   sample;
    logic                   nsample;
    logic                   enable;
    logic                   busy;
    logic [MATRIX_BITS-1:0] p_switch;
    logic [MATRIX_BITS-1:0] n_switch;
    logic [MATRIX_BITS-1:0] result;
    logic                   result_valid;

    modport slave (
        input  start, abort, continuous, avg_control, sample_cycles, comparator_in,
               weight_we, weight_addr, weight_data,
        output sample, nsample, enable, busy, p_switch, n_switch, result, result_valid
    );

    modport master (
        output start, abort, continuous, avg_control, sample_cycles, comparator_in,
               weight_we, weight_addr, weight_data,
        input  sample, nsample, enable, busy, p_switch, n_switch, result, result_valid
    );
endinterface

// File: rtl/sar_ctrl_param.sv
// Nonbinary successive-approximation controller with optional majority averaging
// of the final AVG_STEPS decisions.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - sar_ctrl_param_if.slave: start/abort/continuous, averaging exponent,
//          sample length, comparator decision, weight write port, matrix switch
//          drives, status flags and the conversion result with its valid pulse.
module sar_ctrl_param #(
    parameter int MATRIX_BITS = 12,
    parameter int STEPS       = 15,
    parameter int AVG_STEPS   = 4
) (
    input logic            clk,
    input logic            rst,
    sar_ctrl_param_if.slave bus
);
    localparam int KW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [KW-1:0] LAST_K    = KW'(STEPS - 1);
    localparam logic [KW-1:0] AVG_K     = KW'(STEPS - AVG_STEPS);
    localparam logic [KW:0]   STEPS_EXT = (KW + 1)'(STEPS);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

    // Power-on weight table; only defined for the 12-bit / 15-step matrix.
    function automatic logic [MATRIX_BITS-1:0] reset_weight(input int idx);
        int v;
        v = 0;
        if (MATRIX_BITS == 12 && STEPS == 15) begin
            case (idx)
                0:  v = 1792;
                1:  v = 1024;
                2:  v = 512;
                3:  v = 320;
                4:  v = 192;
                5:  v = 96;
                6:  v = 64;
                7:  v = 32;
                8:  v = 24;
                9:  v = 16;
                10: v = 10;
                11: v = 6;
                12: v = 4;
                13: v = 2;
                14: v = 1;
                default: v = 0;
            endcase
        end
        return MATRIX_BITS'(v);
    endfunction

    state_t                 state_q, state_d;
    logic [MATRIX_BITS-1:0] data_q, data_d;
    logic [MATRIX_BITS-1:0] result_q, result_d;
    logic                   rvalid_q, rvalid_d;
    logic [KW-1:0]          k_q, k_d;
    logic [4:0]             cnt_q, cnt_d;     // sample-cycle count, or cycle within an averaged step
    logic [4:0]             ones_q, ones_d;   // comparator ones seen so far in an averaged step
    logic                   cont_q;
    logic [2:0]             avg_q, smp_q;
    logic [MATRIX_BITS-1:0] w_q [STEPS];

    logic [MATRIX_BITS-1:0] trial;
    logic                   avg_on;
    logic [4:0]             n_last, half, ones_sum;
    logic                   step_done, decision, enter_sample;

    assign trial    = data_q + w_q[k_q];
    assign avg_on   = (avg_q >= 3'd1) && (avg_q <= 3'd4) && (k_q >= AVG_K);
    assign n_last   = (5'd1 << avg_q) - 5'd1;
    assign half     = 5'd1 << (avg_q - 3'd1);
    assign ones_sum = ones_q + {4'd0, bus.comparator_in};

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        result_d     = result_q;
        rvalid_d     = 1'b0;
        k_d          = k_q;
        cnt_d        = cnt_q;
        ones_d       = ones_q;
        step_done    = 1'b0;
        decision     = 1'b0;
        enter_sample = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d      = SAMPLE;
                    enter_sample = 1'b1;
                end
            end
            SAMPLE: begin
                if (cnt_q == {2'b00, smp_q}) begin
                    state_d = CONVERT;
                    data_d  = '0;
                    k_d     = '0;
                    cnt_d   = '0;
                    ones_d  = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            CONVERT: begin
                if (avg_on) begin
                    // Majority vote: the last cycle of the step includes its own decision.
                    if (cnt_q == n_last) begin
                        step_done = 1'b1;
                        decision  = (ones_sum >= half);
                    end else begin
                        cnt_d  = cnt_q + 5'd1;
                        ones_d = ones_sum;
                    end
                end else begin
                    step_done = 1'b1;
                    decision  = bus.comparator_in;
                end
                if (step_done) begin
                    cnt_d  = '0;
                    ones_d = '0;
                    if (decision) begin
                        data_d = trial;
                    end
                    if (k_q == LAST_K) begin
                        state_d  = DONE;
                        result_d = decision ? trial : data_q;
                        rvalid_d = 1'b1;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            DONE: begin
                if (cont_q) begin
                    state_d      = SAMPLE;
                    enter_sample = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything, including a conversion about to finish.
        if (bus.abort && state_q != IDLE) begin
            state_d      = IDLE;
            result_d     = result_q;
            rvalid_d     = 1'b0;
            cnt_d        = '0;
            ones_d       = '0;
            enter_sample = 1'b0;
        end
        if (enter_sample) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            result_q <= '0;
            rvalid_q <= 1'b0;
            k_q      <= '0;
            cnt_q    <= '0;
            ones_q   <= '0;
            cont_q   <= 1'b0;
            avg_q    <= '0;
            smp_q    <= '0;
            for (int i = 0; i < STEPS; i++) begin
                w_q[i] <= reset_weight(i);
            end
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            ones_q   <= ones_d;
            if (enter_sample) begin
                cont_q <= bus.continuous;
                avg_q  <= bus.avg_control;
                smp_q  <= bus.sample_cycles;
            end
            if (state_q == IDLE && bus.weight_we && ({1'b0, bus.weight_addr} < STEPS_EXT)) begin
                w_q[bus.weight_addr] <= bus.weight_data;
            end
        end
    end

    assign bus.sample       = (state_q == IDLE) || (state_q == SAMPLE);
    assign bus.nsample      = ~bus.sample;
    assign bus.enable       = (state_q == SAMPLE) || (state_q == CONVERT);
    assign bus.busy         = (state_q != IDLE);
    assign bus.n_switch     = (state_q == CONVERT) ? trial : '0;
    assign bus.p_switch     = ~bus.n_switch;
    assign bus.result       = result_q;
    assign bus.result_valid = rvalid_q;
endmodule

// File: tb/tb_sar_ctrl_param.sv
module tb_sar_ctrl_param;
    localparam int MB = 12;
    localparam int ST = 15;
    localparam int AS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sar_ctrl_param_if #(.MATRIX_BITS(MB), .STEPS(ST)) bus ();
    sar_ctrl_param #(.MATRIX_BITS(MB), .STEPS(ST), .AVG_STEPS(AS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_w [ST];
    bit          comp_bits [$];
    logic [11:0] exp_ns [$];
    logic [11:0] exp_res;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void default_weights();
        m_w = '{1792, 1024, 512, 320, 192, 96, 64, 32, 24, 16, 10, 6, 4, 2, 1};
    endfunction

    // Builds the comparator stream for one conversion and the switch values and
    // result it must produce, straight from the step/averaging rules.
    task automatic build_model(input int a, input int mode);
        int data;
        data = 0;
        comp_bits.delete();
        exp_ns.delete();
        for (int k = 0; k < ST; k++) begin
            bit avg;
            bit b;
            bit d;
            int n;
            int ones;
            avg  = (a >= 1 && a <= 4 && k >= ST - AS);
            n    = avg ? (1 << a) : 1;
            ones = 0;
            b    = 1'b0;
            for (int j = 0; j < n; j++) begin
                case (mode)
                    1:       b = 1'b1;
                    2:       b = 1'b0;
                    3:       b = avg ? ((j % 4) < 2) : 1'b1;
                    default: b = 1'($urandom);
                endcase
                comp_bits.push_back(b);
                exp_ns.push_back(12'((data + m_w[k]) % 4096));
                ones += int'(b);
            end
            d = avg ? (ones >= n / 2) : b;
            if (d) data = (data + m_w[k]) % 4096;
        end
        exp_res = 12'(data);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_result"}, 32'(bus.result), 0);
        check_eq({tag, "_rvalid"}, 32'(bus.result_valid), 0);
        check_eq({tag, "_enable"}, 32'(bus.enable), 0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 0);
        check_eq({tag, "_sample"}, 32'(bus.sample), 1);
        check_eq({tag, "_nsample"}, 32'(bus.nsample), 0);
        check_eq({tag, "_nsw"}, 32'(bus.n_switch), 0);
        check_eq({tag, "_psw"}, 32'(bus.p_switch), 32'hFFF);
    endtask

    // One full conversion started from IDLE at a falling edge.
    task automatic run_conv(input int sc, input int a, input int mode, input bit busy_write);
        int exp_done;
        int idx;
        logic [11:0] e;
        logic [11:0] pe;
        build_model(a, mode);
        exp_done = sc + 1 + ST + ((a >= 1 && a <= 4) ? AS * ((1 << a) - 1) : 0) + 1;
        bus.start         = 1'b1;
        bus.continuous    = 1'b0;
        bus.avg_control   = 3'(a);
        bus.sample_cycles = 3'(sc);
        @(negedge clk);
        // Captured controls must not follow later input changes.
        bus.continuous    = 1'($urandom);
        bus.avg_control   = 3'($urandom);
        bus.sample_cycles = 3'($urandom);
        idx = 0;
        for (int cyc = 1; cyc <= exp_done; cyc++) begin
            bus.start     = 1'b0;
            bus.weight_we = 1'b0;
            if (cyc <= sc + 1) begin
                check_eq("smp_sample", 32'(bus.sample), 1);
                check_eq("smp_enable", 32'(bus.enable), 1);
                check_eq("smp_busy", 32'(bus.busy), 1);
                check_eq("smp_nsw", 32'(bus.n_switch), 0);
                check_eq("smp_rvalid", 32'(bus.result_valid), 0);
                bus.comparator_in = 1'($urandom);
            end else if (cyc < exp_done) begin
                e  = exp_ns[idx];
                pe = ~e;
                bus.comparator_in = comp_bits[idx];
                idx++;
                check_eq("cnv_nsw", 32'(bus.n_switch), 32'(e));
                check_eq("cnv_psw", 32'(bus.p_switch), 32'(pe));
                check_eq("cnv_sample", 32'(bus.sample), 0);
                check_eq("cnv_nsample", 32'(bus.nsample), 1);
                check_eq("cnv_enable", 32'(bus.enable), 1);
                check_eq("cnv_rvalid", 32'(bus.result_valid), 0);
                bus.start = 1'($urandom);
                if (busy_write && cyc == sc + 3) begin
                    bus.weight_we   = 1'b1;
                    bus.weight_addr = '0;
                    bus.weight_data = 12'd5;
                end
            end else begin
                check_eq("done_rvalid", 32'(bus.result_valid), 1);
                check_eq("done_result", 32'(bus.result), 32'(exp_res));
                check_eq("done_enable", 32'(bus.enable), 0);
                check_eq("done_sample", 32'(bus.sample), 0);
                check_eq("done_busy", 32'(bus.busy), 1);
            end
            @(negedge clk);
        end
        bus.weight_we = 1'b0;
        check_eq("post_busy", 32'(bus.busy), 0);
        check_eq("post_rvalid", 32'(bus.result_valid), 0);
        check_eq("post_result", 32'(bus.result), 32'(exp_res));
        bus.continuous = 1'b0;
    endtask

    task automatic write_weight(input int addr, input int val);
        bus.weight_we   = 1'b1;
        bus.weight_addr = 4'(addr);
        bus.weight_data = 12'(val);
        @(negedge clk);
        bus.weight_we = 1'b0;
        if (addr < ST) m_w[addr] = val;
    endtask

    task automatic abort_at(input int at_cyc);
        logic [11:0] prev;
        int rv_cnt;
        prev = bus.result;
        bus.start = 1'b1;
        bus.continuous = 1'b1;
        bus.avg_control = 3'd0;
        bus.sample_cycles = 3'd0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 1; cyc < at_cyc; cyc++) begin
            bus.comparator_in = 1'($urandom);
            @(negedge clk);
        end
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        bus.continuous = 1'b0;
        check_eq("abort_busy", 32'(bus.busy), 0);
        check_eq("abort_rvalid", 32'(bus.result_valid), 0);
        check_eq("abort_result", 32'(bus.result), 32'(prev));
        rv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.result_valid || bus.busy) rv_cnt++;
            @(negedge clk);
        end
        check_eq("abort_quiet", 32'(rv_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses [$];
        int busy_after;
        int quiet;
        default_weights();
        rst               = 1'b0;
        bus.start         = 1'b0;
        bus.abort         = 1'b0;
        bus.continuous    = 1'b0;
        bus.avg_control   = 3'd0;
        bus.sample_cycles = 3'd0;
        bus.comparator_in = 1'b0;
        bus.weight_we     = 1'b0;
        bus.weight_addr   = '0;
        bus.weight_data   = '0;
        #2;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed: full scale, zero scale, averaged majority pattern
        run_conv(0, 0, 1, 1'b0);
        run_conv(0, 0, 2, 1'b0);
        run_conv(0, 2, 3, 1'b0);

        // Randomized conversions
        for (int i = 0; i < 10; i++) begin
            run_conv(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0, 1'b0);
        end

        // Continuous mode, dropped during the second conversion
        bus.comparator_in = 1'b1;
        bus.avg_control   = 3'd0;
        bus.sample_cycles = 3'd0;
        bus.continuous    = 1'b1;
        bus.start         = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        busy_after = -1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (bus.result_valid) pulses.push_back(cyc);
            if (cyc == 22) bus.continuous = 1'b0;
            if (cyc == 52) busy_after = int'(bus.busy);
            @(negedge clk);
        end
        check_eq("cont_npulses", 32'(pulses.size()), 3);
        if (pulses.size() == 3) begin
            check_eq("cont_first", 32'(pulses[0]), 17);
            check_eq("cont_gap1", 32'(pulses[1] - pulses[0]), 17);
            check_eq("cont_gap2", 32'(pulses[2] - pulses[1]), 17);
        end
        check_eq("cont_idle", 32'(busy_after), 0);
        check_eq("cont_result", 32'(bus.result), 4095);

        // Abort in SAMPLE, in step 5, and in the final step
        abort_at(1);
        abort_at(7);
        abort_at(16);

        // Weight writes: legal in IDLE, ignored while busy and out of range
        write_weight(0, 2048);
        write_weight(15, 77);
        run_conv(0, 0, 1, 1'b1);
        run_conv(1, 3, 0, 1'b0);

        // Reset mid-conversion
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 1; cyc < 8; cyc++) begin
            bus.comparator_in = 1'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        default_weights();
        @(negedge clk);
        rst = 1'b1;
        quiet = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.result_valid || bus.busy) quiet++;
            @(negedge clk);
        end
        check_eq("midrst_quiet", 32'(quiet), 0);
        run_conv(0, 0, 1, 1'b0);
        run_conv(2, 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sar_ctrl_param.md
SAR_CTRL_PARAM -- requirements
Module: sar_ctrl_param

Interface
REQ-001 Parameter MATRIX_BITS, default 12, is the capacitor-matrix and result width.
REQ-002 Parameter STEPS, default 15, is the number of nonbinary conversion steps, index 0 (MSB) to STEPS-1 (LSB).
REQ-003 Parameter AVG_STEPS, default 4, is the number of final steps eligible for averaging; its legal range is 1..STEPS.
REQ-004 The parameters SHALL be MATRIX_BITS, STEPS and AVG_STEPS as listed in REQ-001 to REQ-003.
REQ-005 The ports SHALL be:
- clk  in  1  — single clock; all state updates on its rising edge.
- rst  in  1  — asynchronous, active-low reset.
- start  in  1  — begin a conversion; sampled only in IDLE.
- abort  in  1  — synchronous abort; return to IDLE.
- continuous  in  1  — back-to-back conversion mode; captured at SAMPLE entry.
- avg_control  in  3  — averaging exponent a; captured at SAMPLE entry.
- sample_cycles  in  3  — extra sample cycles; captured at SAMPLE entry.
- comparator_in  in  1  — comparator decision; 1 means keep the trial weight.
- weight_we  in  1  — weight write strobe.
- weight_addr  in  $clog2(STEPS)  — weight step index.
- weight_data  in  MATRIX_BITS  — weight value.
- sample  out  1  — track switch control.
- nsample  out  1  — complement of sample.
- enable  out  1  — comparator enable.
- busy  out  1  — high whenever the state is not IDLE.
- p_switch  out  MATRIX_BITS  — p-side matrix switches.
- n_switch  out  MATRIX_BITS  — n-side matrix switches.
- result  out  MATRIX_BITS  — last completed conversion.
- result_valid  out  1  — one-cycle pulse marking a new result.

Function
REQ-006 The FSM SHALL have four states: IDLE, SAMPLE, CONVERT and DONE.
REQ-007 In IDLE, start=1 SHALL move to SAMPLE at the next edge.
REQ-008 SAMPLE SHALL last sample_cycles+1 cycles, using the value captured on entry.
REQ-009 At SAMPLE entry, avg_control, continuous and sample_cycles SHALL be captured; later changes to these inputs SHALL have no effect until the next SAMPLE entry.
REQ-010 sample SHALL be 1 in IDLE and SAMPLE, and 0 otherwise; nsample SHALL always equal ~sample.
REQ-011 enable SHALL be 1 in SAMPLE and CONVERT, and 0 in IDLE and DONE.
REQ-012 On CONVERT entry, the data register SHALL be cleared and the step index k set to 0.
REQ-013 In CONVERT, trial = data + w[k], computed modulo 2^MATRIX_BITS; n_switch SHALL equal trial and p_switch SHALL equal ~trial.
REQ-014 Outside CONVERT, n_switch SHALL be 0 and p_switch SHALL be all ones.
REQ-015 Each step SHALL resolve to a decision d; if d=1, data SHALL be set to trial at the end of the step, otherwise data SHALL be held.
REQ-016 Averaged steps: if 1<=a<=4 and k>=STEPS-AVG_STEPS, step k SHALL last N=2^a cycles with k held.
REQ-017 During an averaged step, the block SHALL count the cycles with comparator_in=1; d SHALL be 1 iff that count is >= N/2.
REQ-018 For a=0 or a>4, every step SHALL last exactly 1 cycle with d=comparator_in.
REQ-019 Once step STEPS-1 has resolved, the FSM SHALL go to DONE.
REQ-020 In DONE (1 cycle), result SHALL be loaded with the final data value and result_valid SHALL be 1.
REQ-021 From DONE, the next state SHALL be SAMPLE if the captured continuous value is 1, otherwise IDLE.
REQ-022 Latency: numbering the first SAMPLE cycle as cycle 1, DONE SHALL occur in cycle (sample_cycles+1) + STEPS + AVG_STEPS*(N-1) + 1.
REQ-023 abort=1 in any state other than IDLE SHALL move to IDLE at the next edge; result and result_valid SHALL be left unchanged.
REQ-024 abort SHALL take priority over start, and over the DONE transition.
REQ-025 start asserted outside IDLE SHALL be ignored; there is no queuing.
REQ-026 A weight write, w[weight_addr] <= weight_data, SHALL take effect only when weight_we=1 in IDLE.
REQ-027 A weight write in any other state, or to an address >= STEPS, SHALL be ignored.
REQ-028 Trial overflow SHALL wrap modulo 2^MATRIX_BITS; avoiding overflow by choosing suitable weights is the user's responsibility.

Reset
REQ-029 On rst=0, asynchronously: state=IDLE, data=0, counters=0 and captured controls=0.
REQ-030 On rst=0, the outputs SHALL be result=0, result_valid=0, enable=0, busy=0, sample=1, n_switch=0 and p_switch=all ones.
REQ-031 Reset weights, for MATRIX_BITS=12 and STEPS=15, SHALL be w[0..14] = 1792,1024,512,320,192,96,64,32,24,16,10,6,4,2,1.
REQ-032 For any other parameter combination, all reset weights SHALL be 0.
REQ-033 Reset asserted mid-conversion SHALL discard the conversion, and no result_valid SHALL follow.

Verification
REQ-034 Defaults, sample_cycles=0, a=0, comparator_in=1 throughout, start pulse -> result=4095, with result_valid in cycle 17 counted from the first SAMPLE cycle.
REQ-035 Same setup with comparator_in=0 -> result=0, n_switch walks the 15 weights one per cycle, and p_switch=~n_switch every cycle.
REQ-036 a=2, comparator pattern 1,1,0,0 in every averaged step and 1 elsewhere -> each averaged step lasts 4 cycles, result=4095, and result_valid arrives in cycle 29.
REQ-037 continuous=1 -> consecutive result_valid pulses 17 cycles apart; dropping continuous mid-conversion still runs one more conversion after the current one, then the FSM goes to IDLE.
REQ-038 abort asserted in CONVERT step 5 -> IDLE next cycle, result unchanged, and no result_valid.
REQ-039 Weight write in IDLE (w[0]=2048) -> used by the next conversion; the same write issued while busy=1 -> no effect on w[0].
